multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; all configuration is by the preprocessor macro in Configuration.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  7  instruction opcode (instr[6:0]).
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7b5  input  1  instr[30].
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 MemReady  input  1  memory access complete; present only with MEM_WAIT_EN.
REQ-009 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath strobes/selects.
REQ-010 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-011 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.

Function
REQ-012 Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-013 Transitions: FETCH->DECODE; DECODE by op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BEQ, 1101111->JAL, any other->FETCH.
REQ-014 Transitions: MEMADR->MEMREAD (op[5]=0) or MEMWRITE (op[5]=1); MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH; EXECUTER/EXECUTEI/JAL->ALUWB->FETCH; BEQ->FETCH.
REQ-015 Per-state outputs (unlisted signals 0): FETCH AdrSrc0 IRWrite1 ALUSrcA00 ALUSrcB10 ALUOp00 ResultSrc10 PCUpdate1; DECODE ALUSrcA01 ALUSrcB01 ALUOp00; MEMADR ALUSrcA10 ALUSrcB01 ALUOp00.
REQ-016 MEMREAD ResultSrc00 AdrSrc1; MEMWB ResultSrc01 RegWrite1; MEMWRITE ResultSrc00 AdrSrc1 MemWrite1; EXECUTER ALUSrcA10 ALUSrcB00 ALUOp10; EXECUTEI ALUSrcA10 ALUSrcB01 ALUOp10.
REQ-017 ALUWB ResultSrc00 RegWrite1; BEQ ALUSrcA10 ALUSrcB00 ALUOp01 ResultSrc00 Branch1; JAL ALUSrcA01 ALUSrcB10 ALUOp00 ResultSrc00 PCUpdate1.
REQ-018 PCWrite = PCUpdate | (Branch & Zero), combinational; Zero sampled in BEQ only.
REQ-019 ALU decode: ALUOp00->000; 01->001; 10 by funct3: 000->001 if op[5]&funct7b5 else 000; 010->101; 110->011; 111->010; other funct3->000.
REQ-020 ImmSrc combinational from op in every state: 0100011->01, 1100011->10, 1101111->11, otherwise 00.
REQ-021 Outputs depend on current state (plus Zero, op/funct fields, MemReady); no output is registered separately.

Reset
REQ-022 reset=1 forces state FETCH immediately, regardless of clk, including mid-instruction.
REQ-023 During and right after reset, outputs equal FETCH values: IRWrite1, PCWrite1, ALUSrcB10, ResultSrc10, all others 0 (MemWrite, RegWrite guaranteed 0).
REQ-024 First rising edge with reset=0 advances FETCH->DECODE.

Configuration
REQ-025 Macro MEM_WAIT_EN: defined -> MemReady port exists; FETCH, MEMREAD, MEMWRITE hold state while MemReady=0 and advance on first edge with MemReady=1.
REQ-026 With MEM_WAIT_EN, in FETCH IRWrite and PCUpdate assert only while MemReady=1 (one PC increment per fetch); MemWrite held 1 throughout MEMWRITE wait; RegWrite never asserted while waiting.
REQ-027 Undefined -> no MemReady port; every state lasts exactly one cycle; behaviour identical to MEM_WAIT_EN with MemReady tied 1.

Verification
REQ-028 lw (op 0000011): FETCH,DECODE,MEMADR,MEMREAD,MEMWB over 5 cycles; RegWrite=1 with ResultSrc=01 only in cycle 5.
REQ-029 sw (op 0100011): 4 cycles; MemWrite=1, AdrSrc=1 only in cycle 4; ImmSrc=01 throughout.
REQ-030 R-type funct3=000 funct7b5=1: ALUControl=001 in EXECUTER; funct7b5=0 -> 000; funct3=010 -> 101; ALUWB RegWrite=1.
REQ-031 beq: Zero=1 in BEQ -> PCWrite=1; Zero=0 -> PCWrite=0; next state FETCH both cases, 3 cycles total.
REQ-032 Assert reset asynchronously mid-MEMWRITE -> state FETCH before next edge, MemWrite drops to 0; illegal op 0000000 in DECODE -> FETCH next cycle, no writes.
REQ-033 MEM_WAIT_EN: MemReady=0 for 3 cycles in FETCH -> PCWrite=0, IRWrite=0, state held; MemReady=1 -> exactly one PCWrite pulse, then DECODE.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle datapath and its controller.
// Optional MemReady handshake is present only when MEM_WAIT_EN is defined.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
`ifdef MEM_WAIT_EN
    logic       MemReady;
`endif
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;

`ifdef MEM_WAIT_EN
    // Datapath side: supplies instruction fields and status, consumes controls.
    modport master (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
    );
    // Controller side.
    modport slave (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
    );
`else
    // Datapath side: supplies instruction fields and status, consumes controls.
    modport master (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
    );
    // Controller side.
    modport slave (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
    );
`endif
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style main controller: Moore FSM, ALU decoder, immediate
// select. Define MEM_WAIT_EN to add MemReady stalls in FETCH/MEMREAD/MEMWRITE.
module multicycle_ctrl (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.slave   bus
);
    localparam int unsigned STATE_W = 4;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_mem_ready;
    logic       w_pc_update;
    logic       w_branch;
    logic [1:0] w_alu_op;

`ifdef MEM_WAIT_EN
    assign w_mem_ready = bus.MemReady;
`else
    assign w_mem_ready = 1'b1;
`endif

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    // Next-state logic; memory states hold until the access completes.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    if (w_mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECUTER;
                    OP_I:         w_next_state = S_EXECUTEI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JAL;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (w_mem_ready) w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: if (w_mem_ready) w_next_state = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL: w_next_state = S_ALUWB;
            S_ALUWB, S_BEQ:                w_next_state = S_FETCH;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Per-state datapath controls; FETCH strobes wait for the fetch to land.
    always_comb begin
        w_pc_update   = 1'b0;
        w_branch      = 1'b0;
        w_alu_op      = 2'b00;
        bus.AdrSrc    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        case (r_state)
            S_FETCH: begin
                bus.IRWrite   = w_mem_ready;
                w_pc_update   = w_mem_ready;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            S_DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMREAD:  bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                bus.ALUSrcA = 2'b10;
                w_alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                w_alu_op    = 2'b10;
            end
            S_ALUWB:    bus.RegWrite = 1'b1;
            S_BEQ: begin
                bus.ALUSrcA = 2'b10;
                w_alu_op    = 2'b01;
                w_branch    = 1'b1;
            end
            S_JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                w_pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite = w_pc_update | (w_branch & bus.Zero);

    // ALU decoder: subtract only for R-type with funct7b5 set.
    always_comb begin
        bus.ALUControl = 3'b000;
        case (w_alu_op)
            2'b01: bus.ALUControl = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  bus.ALUControl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  bus.ALUControl = 3'b101;
                    3'b110:  bus.ALUControl = 3'b011;
                    3'b111:  bus.ALUControl = 3'b010;
                    default: bus.ALUControl = 3'b000;
                endcase
            end
            default: bus.ALUControl = 3'b000;
        endcase
    end

    // Immediate format select, driven from the opcode in every state.
    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: driver queues per-cycle expected
// control vectors, monitor compares at each falling edge (or on demand).
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          total = 0;
    int          bad   = 0;
    event        sample_ev;
    logic [15:0] act;

    assign act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                  bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl};

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl}
    function automatic logic [15:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] asa, input logic [1:0] asb,
                                       input logic [1:0] imm, input logic [2:0] alu);
        return {pcw, adr, mw, irw, rw, rs, asa, asb, imm, alu};
    endfunction

    // Monitor: pop one expectation per falling edge or explicit sample request.
    initial begin
        forever begin
            @(negedge clk or sample_ev);
            if (q.size() > 0) begin
                cur = q.pop_front();
                total++;
                if (act !== cur.v) begin
                    bad++;
                    $display("FAIL %s: got %b want %b", cur.name, act, cur.v);
                end
            end
        end
    end

    // Queue the expectation for the current cycle, then move to the next cycle.
    task automatic cyc(input logic [15:0] v, input string n);
        q.push_back('{v: v, name: n});
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.Zero     = z;
    endtask

    initial begin
        reset        = 1'b1;
        bus.op       = 7'b0000000;
        bus.funct3   = 3'b000;
        bus.funct7b5 = 1'b0;
        bus.Zero     = 1'b0;
`ifdef MEM_WAIT_EN
        bus.MemReady = 1'b1;
`endif
        @(posedge clk);
        #1;
        // Held in reset: FETCH outputs.
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000), "reset_fetch");
        reset = 1'b0;

        // lw: 5 cycles, write-back only in the last.
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000), "lw_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000), "lw_decode");
        cyc(mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000), "lw_memadr");
        cyc(mk(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000), "lw_memread");
        cyc(mk(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000), "lw_memwb");

        // sw: 4 cycles, ImmSrc=01 throughout.
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000), "sw_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000), "sw_decode");
        cyc(mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000), "sw_memadr");
        cyc(mk(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000), "sw_memwrite");

        // R-type sub.
        set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000), "sub_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000), "sub_decode");
        cyc(mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001), "sub_execr");
        cyc(mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000), "sub_aluwb");

        // R-type add.
        set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000), "add_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000), "add_decode");
        cyc(mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000), "add_execr");
        cyc(mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000), "add_aluwb");

        // R-type slt.
        set_instr(7'b0110011, 3'b010, 1'b0, 1'b0);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000), "slt_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000), "slt_decode");
        cyc(mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b101), "slt_execr");
        cyc(mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000), "slt_aluwb");

        // addi with funct7b5=1 must still add (op[5]=0).
        set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000), "addi_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000), "addi_decode");
        cyc(mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000), "addi_execi");
        cyc(mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000), "addi_aluwb");

        // ori / andi.
        set_instr(7'b0010011, 3'b110, 1'b0, 1'b0);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000), "ori_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000), "ori_decode");
        cyc(mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b011), "ori_execi");
        cyc(mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000), "ori_aluwb");
        set_instr(7'b0010011, 3'b111, 1'b0, 1'b0);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000), "andi_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000), "andi_decode");
        cyc(mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b010), "andi_execi");
        cyc(mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000), "andi_aluwb");

        // beq taken then not taken; 3 cycles each.
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000), "beqt_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000), "beqt_decode");
        cyc(mk(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001), "beqt_beq");
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000), "beqn_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000), "beqn_decode");
        cyc(mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001), "beqn_beq");

        // jal.
        set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b11,3'b000), "jal_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000), "jal_decode");
        cyc(mk(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000), "jal_jal");
        cyc(mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000), "jal_aluwb");

        // Illegal opcode: DECODE goes straight back to FETCH with no writes.
        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000), "ill_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000), "ill_decode");

        // sw interrupted by asynchronous reset in MEMWRITE.
        set_instr(7'b0100011, 3'b000, 1'b0, 1'b0);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000), "ill_next_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000), "sw2_decode");
        cyc(mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000), "sw2_memadr");
        q.push_back('{v: mk(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000), name: "sw2_memwrite"});
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        q.push_back('{v: mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000), name: "async_reset"});
        -> sample_ev;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // lw resumes normally after reset.
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000), "lw2_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000), "lw2_decode");
        cyc(mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000), "lw2_memadr");
        cyc(mk(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000), "lw2_memread");
        cyc(mk(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000), "lw2_memwb");

`ifdef MEM_WAIT_EN
        // Fetch stall: no strobes while waiting, one PC write when ready.
        set_instr(7'b0010011, 3'b000, 1'b0, 1'b0);
        bus.MemReady = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc(mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000), "wait_fetch_stall");
        bus.MemReady = 1'b1;
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000), "wait_fetch_go");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000), "wait_decode");
        cyc(mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000), "wait_execi");
        cyc(mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000), "wait_aluwb");
        // Store stall: MemWrite held through the wait.
        set_instr(7'b0100011, 3'b000, 1'b0, 1'b0);
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000), "wsw_fetch");
        cyc(mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000), "wsw_decode");
        cyc(mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000), "wsw_memadr");
        bus.MemReady = 1'b0;
        cyc(mk(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000), "wsw_memwrite_wait");
        cyc(mk(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000), "wsw_memwrite_wait");
        bus.MemReady = 1'b1;
        cyc(mk(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000), "wsw_memwrite_go");
        cyc(mk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000), "wsw_next_fetch");
`endif

        // Every queued expectation must have been consumed by the monitor.
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
